// File: rtl/wisc_pkg.sv
// Shared definitions for the fetch front end: data widths, the opcode
// field location, the HLT opcode and the fetch-control state encoding.
package wisc_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  // Opcode occupies the top nibble of every instruction word.
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;

  localparam logic [3:0] OP_HLT = 4'hF;

  // RUN issues fetches; HALT stops issuing until a redirect arrives.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // True when the instruction word carries the HLT opcode.
  function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer between instruction memory and decode.
// Entries are kept in a shift arrangement so entry 0 is always the head.
// The head outputs therefore come straight from registers, and every slot
// beyond the fill level is held at zero, so the head reads zero when empty.
// Push and pop may happen together at any fill level; flush wins over both.
module fetch_fifo
  import wisc_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic [ADDR_W-1:0]  push_pc_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [CW-1:0]      count_o,
  output logic               head_valid_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [ADDR_W-1:0]  head_pc_o
);

  localparam int EW = INSTR_W + ADDR_W;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_slot;
  logic          pop_ok;

  // Next-state of the storage: shift on pop, then write the new entry at
  // the first free slot after the shift.
  always_comb begin
    pop_ok  = pop_i & (count_q != '0);
    wr_slot = pop_ok ? (count_q - CW'(1)) : count_q;
    mem_d   = mem_q;
    count_d = count_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      count_d = '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_d[i] = mem_q[i+1];
        end
        mem_d[DEPTH-1] = '0;
      end
      // A push onto a full buffer without a pop has no slot and is dropped;
      // the issue rule upstream never lets that happen.
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (wr_slot == CW'(i))) begin
          mem_d[i] = {push_instr_i, push_pc_i};
        end
      end
      count_d = count_q + CW'(push_i) - CW'(pop_ok);
    end
  end

  // Storage and fill-level registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);
  assign head_instr_o = mem_q[0][EW-1:ADDR_W];
  assign head_pc_o    = mem_q[0][ADDR_W-1:0];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Holds the PC, issues one read per cycle to a
// synchronous-read instruction memory, and buffers returned words in a
// small FIFO so decode can stall without losing fetches.
//
// Handshake: decode takes the head when if_valid & id_ready in the same
// cycle; if_valid never drops while the head is waiting, and the head
// contents are stable until taken. A redirect discards the buffer and any
// read whose data arrives in the redirect cycle; the first read at the
// new address goes out one cycle later.
//
// Issue keeps one slot reserved for every read in flight, so a returning
// word always has room. Once a HLT word returns, issuing stops until a
// redirect or reset. hlt_fetched mirrors the fetch FSM state.
module if_fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               hlt_fetched
);

  // DEPTH must be at least 2 for back-to-back issue to sustain one
  // instruction per cycle.
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e      state_q;
  logic              hlt_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic [ADDR_W-1:0] req_pc_d;
  logic              inflight_q;
  logic              inflight_d;

  logic [CW-1:0]      fifo_count;
  logic               fifo_valid;
  logic [INSTR_W-1:0] fifo_instr;
  logic [ADDR_W-1:0]  fifo_pc;

  logic pop;
  logic ret_hlt;
  logic push;
  logic has_space;
  logic issue;

  // Issue decision and buffer control for this cycle.
  always_comb begin
    // Decode's take is ignored in a redirect cycle; the buffer is flushed.
    pop       = fifo_valid & id_ready & ~redirect_valid;
    ret_hlt   = inflight_q & is_hlt(imem_rdata);
    push      = inflight_q & ~redirect_valid;
    has_space = (int'(fifo_count) + int'(inflight_q)) < DEPTH;
    // A HLT arriving this cycle blocks the issue that would otherwise
    // follow it, so nothing past the HLT is ever requested.
    issue     = ~rst & ~redirect_valid & (state_q == RUN) & ~ret_hlt &
                (has_space | pop);
  end

  // Next PC, recorded request PC and in-flight flag.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d     = pc_q + ADDR_W'(1);
      req_pc_d = pc_q;
    end
  end

  // PC and outstanding-read tracking; reset overrides redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  // Fetch FSM: RUN until a HLT word returns, back to RUN on redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      hlt_q   <= 1'b0;
    end else if (redirect_valid) begin
      state_q <= RUN;
      hlt_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (ret_hlt) begin
            state_q <= HALT;
            hlt_q   <= 1'b1;
          end
        end
        HALT: begin
          state_q <= HALT;
          hlt_q   <= 1'b1;
        end
        default: begin
          state_q <= RUN;
          hlt_q   <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push),
    .push_instr_i (imem_rdata),
    .push_pc_i    (req_pc_q),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .count_o      (fifo_count),
    .head_valid_o (fifo_valid),
    .head_instr_o (fifo_instr),
    .head_pc_o    (fifo_pc)
  );

  assign imem_addr   = pc_q;
  assign imem_rd_en  = issue;
  assign if_valid    = fifo_valid;
  assign if_instr    = fifo_instr;
  assign if_pc       = fifo_pc;
  // Return address for calls; held at zero while the buffer is empty.
  assign if_pc_plus1 = fifo_valid ? (fifo_pc + ADDR_W'(1)) : '0;
  assign hlt_fetched = hlt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a per-cycle vector table for reset and
// streaming, hand-written sequences for stall, redirect, HLT, reset
// during activity and PC wrap, and a scoreboard of expected deliveries.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        id_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  logic [15:0] imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus1;
  logic        imem_rd_en, if_valid, hlt_fetched;

  logic [15:0] w_imem_addr, w_imem_rdata, w_if_instr, w_if_pc, w_if_pc_plus1;
  logic        w_imem_rd_en, w_if_valid, w_hlt_fetched;

  logic [15:0] pend_a, pend_w;
  logic        hlt_en;
  logic        sb_on;
  logic [31:0] exp_q[$];
  int          tests;
  int          failed;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus1    (if_pc_plus1),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hlt_fetched    (hlt_fetched)
  );

  if_fetch_stage #(.RESET_PC(16'hFFFE), .DEPTH(2)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (w_imem_addr),
    .imem_rd_en     (w_imem_rd_en),
    .imem_rdata     (w_imem_rdata),
    .if_valid       (w_if_valid),
    .if_instr       (w_if_instr),
    .if_pc          (w_if_pc),
    .if_pc_plus1    (w_if_pc_plus1),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hlt_fetched    (w_hlt_fetched)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents: opcode 1 everywhere, HLT at address 3 when enabled.
  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic h);
    if (h && a == 16'h0003) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mid-cycle sample point: capture memory requests, run the scoreboard.
  task automatic half();
    logic [31:0] e;
    logic [15:0] e_pc1;
    @(negedge clk);
    pend_a = imem_rd_en ? mem_word(imem_addr, hlt_en) : 16'hDEAD;
    pend_w = w_imem_rd_en ? mem_word(w_imem_addr, hlt_en) : 16'hDEAD;
    if (sb_on && !rst && if_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL sb_unexpected: got pc %h with no delivery expected", if_pc);
      end else begin
        e = exp_q.pop_front();
        e_pc1 = e[15:0] + 16'd1;
        chk("sb_pc", {16'h0, if_pc}, {16'h0, e[15:0]});
        chk("sb_instr", {16'h0, if_instr}, {16'h0, e[31:16]});
        chk("sb_pc_plus1", {16'h0, if_pc_plus1}, {16'h0, e_pc1});
      end
    end
  endtask

  // Active edge, then drive memory read data for the new cycle.
  task automatic adv();
    @(posedge clk);
    #1;
    imem_rdata   = pend_a;
    w_imem_rdata = pend_w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0;
    sb_on = 1'b0;
    exp_q.delete();
    half(); adv();
    half(); adv();
  endtask

  task automatic push_exp(input logic [15:0] pc);
    exp_q.push_back({mem_word(pc, hlt_en), pc});
  endtask

  task automatic drain_check(input string name);
    id_ready = 1'b0;
    half();
    chk(name, exp_q.size(), 0);
    sb_on = 1'b0;
    adv();
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_pc;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_hlt;
  } vec_t;

  vec_t vec[7];

  initial begin
    logic [15:0] e_instr, e_pc1, wpc, wpc1;
    tests = 0;
    failed = 0;
    hlt_en = 1'b0;
    sb_on = 1'b0;
    rst = 1'b1;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0;
    pend_a = 16'hDEAD;
    pend_w = 16'hDEAD;
    imem_rdata = 16'hDEAD;
    w_imem_rdata = 16'hDEAD;

    // Reset then streaming with decode always ready.
    vec[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vec[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vec[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vec[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0002, 1'b0};
    vec[4] = '{1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0003, 1'b0};
    vec[5] = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0004, 1'b0};
    vec[6] = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0005, 1'b0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      rst = vec[i].rst;
      id_ready = vec[i].rdy;
      half();
      e_instr = vec[i].e_valid ? mem_word(vec[i].e_pc, 1'b0) : 16'h0;
      e_pc1 = vec[i].e_valid ? (vec[i].e_pc + 16'd1) : 16'h0;
      chk($sformatf("vec%0d_valid", i), {31'h0, if_valid}, {31'h0, vec[i].e_valid});
      chk($sformatf("vec%0d_pc", i), {16'h0, if_pc}, {16'h0, vec[i].e_valid ? vec[i].e_pc : 16'h0});
      chk($sformatf("vec%0d_instr", i), {16'h0, if_instr}, {16'h0, e_instr});
      chk($sformatf("vec%0d_pc_plus1", i), {16'h0, if_pc_plus1}, {16'h0, e_pc1});
      chk($sformatf("vec%0d_rd_en", i), {31'h0, imem_rd_en}, {31'h0, vec[i].e_rd});
      chk($sformatf("vec%0d_addr", i), {16'h0, imem_addr}, {16'h0, vec[i].e_addr});
      chk($sformatf("vec%0d_hlt", i), {31'h0, hlt_fetched}, {31'h0, vec[i].e_hlt});
      adv();
    end

    // Decode stalled for 5 cycles, then released.
    do_reset();
    rst = 1'b0;
    sb_on = 1'b1;
    for (int p = 0; p < 4; p++) push_exp(16'(p));
    for (int c = 0; c < 5; c++) begin
      half();
      chk($sformatf("stall_rd_en_c%0d", c), {31'h0, imem_rd_en}, {31'h0, (c < 2)});
      if (c >= 2) begin
        chk($sformatf("stall_head_valid_c%0d", c), {31'h0, if_valid}, 32'h1);
        chk($sformatf("stall_head_pc_c%0d", c), {16'h0, if_pc}, 32'h0);
      end
      adv();
    end
    id_ready = 1'b1;
    for (int c = 5; c < 9; c++) begin
      half();
      chk($sformatf("stall_nogap_c%0d", c), {31'h0, if_valid}, 32'h1);
      adv();
    end
    drain_check("stall_drain");

    // Redirect while the buffer holds an entry and a read is returning.
    do_reset();
    rst = 1'b0;
    sb_on = 1'b1;
    half(); adv();
    half(); adv();
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    push_exp(16'h0040);
    push_exp(16'h0041);
    push_exp(16'h0042);
    half();
    chk("redir_no_issue", {31'h0, imem_rd_en}, 32'h0);
    adv();
    redirect_valid = 1'b0;
    half();
    chk("redir_t1_valid", {31'h0, if_valid}, 32'h0);
    chk("redir_t1_rd_en", {31'h0, imem_rd_en}, 32'h1);
    chk("redir_t1_addr", {16'h0, imem_addr}, 32'h0040);
    adv();
    half();
    chk("redir_t2_valid", {31'h0, if_valid}, 32'h0);
    adv();
    half();
    chk("redir_t3_valid", {31'h0, if_valid}, 32'h1);
    adv();
    half(); adv();
    half(); adv();
    drain_check("redir_drain");

    // HLT at address 3, then redirect out of HALT.
    hlt_en = 1'b1;
    do_reset();
    rst = 1'b0;
    id_ready = 1'b1;
    sb_on = 1'b1;
    for (int p = 0; p < 4; p++) push_exp(16'(p));
    for (int c = 0; c < 10; c++) begin
      half();
      chk($sformatf("hlt_rd_en_c%0d", c), {31'h0, imem_rd_en}, {31'h0, (c < 4)});
      chk($sformatf("hlt_flag_c%0d", c), {31'h0, hlt_fetched}, {31'h0, (c >= 5)});
      adv();
    end
    half();
    chk("hlt_all_delivered", exp_q.size(), 0);
    adv();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0010;
    push_exp(16'h0010);
    push_exp(16'h0011);
    half(); adv();
    redirect_valid = 1'b0;
    half();
    chk("hlt_cleared", {31'h0, hlt_fetched}, 32'h0);
    chk("hlt_resume_rd_en", {31'h0, imem_rd_en}, 32'h1);
    chk("hlt_resume_addr", {16'h0, imem_addr}, 32'h0010);
    adv();
    half(); adv();
    half();
    chk("hlt_resume_valid", {31'h0, if_valid}, 32'h1);
    adv();
    half(); adv();
    drain_check("hlt_drain");
    hlt_en = 1'b0;

    // Reset and redirect together with a full buffer.
    do_reset();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      half();
      if (c == 3) chk("rst_pre_full_valid", {31'h0, if_valid}, 32'h1);
      adv();
    end
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0055;
    half();
    chk("rst_rd_en_low", {31'h0, imem_rd_en}, 32'h0);
    adv();
    rst = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    sb_on = 1'b1;
    push_exp(16'h0000);
    push_exp(16'h0001);
    half();
    chk("rst_after_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_after_addr", {16'h0, imem_addr}, 32'h0000);
    chk("rst_after_hlt", {31'h0, hlt_fetched}, 32'h0);
    adv();
    half();
    chk("rst_next_addr", {16'h0, imem_addr}, 32'h0001);
    adv();
    half(); adv();
    half(); adv();
    drain_check("rst_drain");

    // PC wrap from RESET_PC = 0xFFFE on the second instance.
    do_reset();
    rst = 1'b0;
    id_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      half();
      if (c == 0) chk("wrap_first_addr", {16'h0, w_imem_addr}, 32'hFFFE);
      if (c >= 2) begin
        wpc = 16'hFFFE;
        wpc = wpc + 16'(c - 2);
        wpc1 = wpc + 16'd1;
        chk($sformatf("wrap_valid_c%0d", c), {31'h0, w_if_valid}, 32'h1);
        chk($sformatf("wrap_pc_c%0d", c), {16'h0, w_if_pc}, {16'h0, wpc});
        chk($sformatf("wrap_instr_c%0d", c), {16'h0, w_if_instr}, {16'h0, mem_word(wpc, 1'b0)});
        chk($sformatf("wrap_pc_plus1_c%0d", c), {16'h0, w_if_pc_plus1}, {16'h0, wpc1});
      end
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
